// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response bus.
// One request in flight; the response strobe follows one cycle later.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO between instruction memory and IF/ID.
// One outstanding read; redirect flushes and discards a late response.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    fetch_queue_if.master          imem,
    output logic [31:0]            instruction,
    output logic [31:0]            PC_plus_4,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          outstanding;
    logic          discard;
    logic          full;
    logic          issue;
    logic          resp;
    logic          push;
    logic          pop;

    // Handshake decisions and zero-latency head outputs.
    always_comb begin
        full           = (count_q == CW'(DEPTH));
        issue          = reset && !redirect && !outstanding && !full;
        resp           = imem.imem_rvalid && outstanding;
        push           = resp && !discard && !redirect;
        valid          = (count_q != '0);
        pop            = valid && !stall && !redirect;
        imem.imem_req  = issue;
        imem.imem_addr = fetch_pc;
        instruction    = valid ? ins_mem[rd_ptr] : 32'h0;
        PC_plus_4      = valid ? pc_mem[rd_ptr] : 32'h0;
        count          = count_q;
    end

    // Control state: fetch address, pointers, occupancy, request tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            if (outstanding && !imem.imem_rvalid) begin
                discard <= 1'b1;
            end else begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
        end else begin
            if (issue) begin
                outstanding <= 1'b1;
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end else if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; head outputs are masked while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= inflight_pc + 32'd4;
            ins_mem[wr_ptr] <= imem.imem_rdata;
        end
    end

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!reset) !(push && full)
    ) else $error("fetch_queue: push into full queue");

endmodule
